// File: rtl/mips_cpu_store_pkg.sv
// Shared opcodes, drain-state encoding and entry layout for the store buffer.
// Entry fields are sized for the widest supported configuration; users slice them down.
package mips_cpu_store_pkg;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam int unsigned SB_MAX_ADDR_W = 64;
  localparam int unsigned SB_MAX_DATA_W = 64;
  localparam int unsigned SB_MAX_LANES  = SB_MAX_DATA_W / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic                     valid;
    logic [SB_MAX_ADDR_W-1:0] waddr;
    logic [SB_MAX_DATA_W-1:0] data;
    logic [SB_MAX_LANES-1:0]  be;
  } sb_entry_t;

endpackage

// File: rtl/mips_cpu_store_align.sv
// Places big-endian register bytes of SB/SH/SW onto memory byte lanes and
// produces lane enables; flags misaligned halfword/word stores and unknown opcodes.
module mips_cpu_store_align
  import mips_cpu_store_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned LANES  = DATA_W / 8,
  localparam int unsigned OFF_W  = $clog2(LANES)
) (
  input  logic [5:0]        op,
  input  logic [OFF_W-1:0]  offset,
  input  logic [31:0]       st_data,
  output logic [DATA_W-1:0] lane_data,
  output logic [LANES-1:0]  be,
  output logic              err
);

  always_comb begin
    lane_data = '0;
    be        = '0;
    err       = 1'b0;
    case (op)
      OP_SB: begin
        lane_data[offset*8 +: 8] = st_data[7:0];
        be[offset]               = 1'b1;
      end
      OP_SH: begin
        if (offset[0]) begin
          err = 1'b1;
        end else begin
          lane_data[offset*8 +: 8]     = st_data[15:8];
          lane_data[(offset+1)*8 +: 8] = st_data[7:0];
          be[offset]                   = 1'b1;
          be[offset+1]                 = 1'b1;
        end
      end
      OP_SW: begin
        if (offset[1:0] != 2'b00) begin
          err = 1'b1;
        end else begin
          for (int unsigned i = 0; i < 4; i++) begin
            lane_data[(offset+i)*8 +: 8] = st_data[31-8*i -: 8];
            be[offset+i]                 = 1'b1;
          end
        end
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_cpu_store_buffer.sv
// Buffered store path: aligns SB/SH/SW, queues them in a DEPTH-entry FIFO and drains
// over a write/waitrequest handshake. Define MIPS_CPU_STORE_COALESCE_EN to merge same-word stores.
module mips_cpu_store_buffer
  import mips_cpu_store_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [5:0]                 st_op,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [31:0]                st_data,
  output logic                       st_err,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_writedata,
  output logic [DATA_W/8-1:0]        mem_byteenable,
  input  logic                       mem_waitrequest,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hazard,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(LANES);
  localparam int unsigned WA_W  = ADDR_W - OFF_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  sb_entry_t          entries [DEPTH];
  logic [PTR_W-1:0]   head, tail, yng, load_idx;
  drain_state_t       state_q, state_d;

  logic [DATA_W-1:0]  a_data, mg_data;
  logic [LANES-1:0]   a_be, mg_be;
  logic               a_err;
  logic [WA_W-1:0]    st_wa;
  logic               merge_hit, accept, do_push, do_merge, pop, load;

  logic               mw_d;
  logic [ADDR_W-1:0]  ma_d;
  logic [DATA_W-1:0]  md_d;
  logic [LANES-1:0]   mb_d;

  mips_cpu_store_align #(.DATA_W(DATA_W)) u_align (
    .op        (st_op),
    .offset    (st_addr[OFF_W-1:0]),
    .st_data   (st_data),
    .lane_data (a_data),
    .be        (a_be),
    .err       (a_err)
  );

  assign st_wa = st_addr[ADDR_W-1:OFF_W];
  assign yng   = tail - PTR_W'(1);

`ifdef MIPS_CPU_STORE_COALESCE_EN
  // The head already on the bus is frozen; merging into it would change a write in flight.
  assign merge_hit = (count != '0) && (entries[yng].waddr[WA_W-1:0] == st_wa) &&
                     !(mem_write && (yng == head));
`else
  assign merge_hit = 1'b0;
`endif

  assign st_ready = (count < CNT_W'(DEPTH)) || merge_hit;
  assign accept   = st_valid && st_ready;
  assign do_push  = accept && !a_err && !merge_hit;
  assign do_merge = accept && !a_err && merge_hit;
  assign empty    = (count == '0);

  always_comb begin
    mg_data = entries[yng].data[DATA_W-1:0];
    for (int unsigned k = 0; k < LANES; k++) begin
      if (a_be[k]) mg_data[k*8 +: 8] = a_data[k*8 +: 8];
    end
    mg_be = entries[yng].be[LANES-1:0] | a_be;
  end

  always_comb begin
    ld_hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && (entries[i].waddr[WA_W-1:0] == ld_addr[ADDR_W-1:OFF_W]))
        ld_hazard = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    mw_d     = mem_write;
    ma_d     = mem_addr;
    md_d     = mem_writedata;
    mb_d     = mem_byteenable;
    pop      = 1'b0;
    load     = 1'b0;
    load_idx = head;
    case (state_q)
      IDLE: begin
        if (entries[head].valid) begin
          state_d = WRITE;
          load    = 1'b1;
        end
      end
      WRITE: begin
        if (!mem_waitrequest) begin
          pop = 1'b1;
          if (count > CNT_W'(1)) begin
            load     = 1'b1;
            load_idx = head + PTR_W'(1);
          end else begin
            state_d = IDLE;
            mw_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      mw_d = 1'b1;
      ma_d = {entries[load_idx].waddr[WA_W-1:0], {OFF_W{1'b0}}};
      // A same-cycle merge into the entry being loaded must reach the bus too.
      if (do_merge && (load_idx == yng)) begin
        md_d = mg_data;
        mb_d = mg_be;
      end else begin
        md_d = entries[load_idx].data[DATA_W-1:0];
        mb_d = entries[load_idx].be[LANES-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      st_err         <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      state_q        <= state_d;
      st_err         <= accept && a_err;
      mem_write      <= mw_d;
      mem_addr       <= ma_d;
      mem_writedata  <= md_d;
      mem_byteenable <= mb_d;
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_W'(1);
      end
      if (do_push) begin
        entries[tail].valid <= 1'b1;
        entries[tail].waddr <= SB_MAX_ADDR_W'(st_wa);
        entries[tail].data  <= SB_MAX_DATA_W'(a_data);
        entries[tail].be    <= SB_MAX_LANES'(a_be);
        tail                <= tail + PTR_W'(1);
      end
      if (do_merge) begin
        entries[yng].data <= SB_MAX_DATA_W'(mg_data);
        entries[yng].be   <= SB_MAX_LANES'(mg_be);
      end
      if (do_push && !pop)      count <= count + CNT_W'(1);
      else if (!do_push && pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_cpu_store_buffer.sv
// Directed bench for mips_cpu_store_buffer (DEPTH=4, ADDR_W=32, DATA_W=32).
module tb_mips_cpu_store_buffer;

  localparam logic [5:0] SB = 6'b101000;
  localparam logic [5:0] SH = 6'b101001;
  localparam logic [5:0] SW = 6'b101011;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        st_valid, st_ready, st_err;
  logic [5:0]  st_op;
  logic [31:0] st_addr, st_data;
  logic        mem_write, mem_waitrequest, ld_hazard, empty;
  logic [31:0] mem_addr, mem_writedata, ld_addr;
  logic [3:0]  mem_byteenable;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int          wr_n = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [3:0]  wr_be   [64];
  int          wr_cyc  [64];

  mips_cpu_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .st_op           (st_op),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_err          (st_err),
    .mem_write       (mem_write),
    .mem_addr        (mem_addr),
    .mem_writedata   (mem_writedata),
    .mem_byteenable  (mem_byteenable),
    .mem_waitrequest (mem_waitrequest),
    .ld_addr         (ld_addr),
    .ld_hazard       (ld_hazard),
    .empty           (empty),
    .count           (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record each write that the memory will take on the coming rising edge.
  always @(negedge clk) begin
    if (reset_n && mem_write && !mem_waitrequest && wr_n < 64) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_writedata;
      wr_be[wr_n]   = mem_byteenable;
      wr_cyc[wr_n]  = cyc;
      wr_n          = wr_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    st_valid = 1'b0; st_op = '0; st_addr = '0; st_data = '0;
    mem_waitrequest = 1'b0; ld_addr = 32'hFFFF_FFF0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_writedata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_data: got %h want 0", mem_writedata); end
    n_cmp++; if (mem_byteenable !== 4'h0) begin n_bad++; $display("FAIL rst_mem_be: got %b want 0000", mem_byteenable); end
    n_cmp++; if (st_err !== 1'b0) begin n_bad++; $display("FAIL rst_st_err: got %b want 0", st_err); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", empty); end
    n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL rst_st_ready: got %b want 1", st_ready); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_sw();
    int base;
    base = wr_n;
    mem_waitrequest = 1'b0;
    st_valid = 1'b1; st_op = SW; st_addr = 32'h100; st_data = 32'h11223344;
    tick();
    st_valid = 1'b0;
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL sw_count_after_accept: got %0d want 1", count); end
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL sw_no_write_yet: got %b want 0", mem_write); end
    n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL sw_not_empty: got %b want 0", empty); end
    tick();
    n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL sw_issue_write: got %b want 1", mem_write); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL sw_addr: got %h want 00000100", mem_addr); end
    n_cmp++; if (mem_writedata !== 32'h44332211) begin n_bad++; $display("FAIL sw_data: got %h want 44332211", mem_writedata); end
    n_cmp++; if (mem_byteenable !== 4'b1111) begin n_bad++; $display("FAIL sw_be: got %b want 1111", mem_byteenable); end
    n_cmp++; if (st_err !== 1'b0) begin n_bad++; $display("FAIL sw_no_err: got %b want 0", st_err); end
    tick();
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL sw_write_drop: got %b want 0", mem_write); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL sw_empty_after: got %b want 1", empty); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL sw_count_after: got %0d want 0", count); end
    n_cmp++; if (wr_n - base !== 1) begin n_bad++; $display("FAIL sw_write_count: got %0d want 1", wr_n - base); end
  endtask

  task automatic test_sb_sh();
    int base;
    base = wr_n;
    mem_waitrequest = 1'b0;
    st_valid = 1'b1; st_op = SB; st_addr = 32'h203; st_data = 32'h000000AB;
    tick();
    st_op = SH; st_addr = 32'h202; st_data = 32'h0000CDEF;
    tick();
    st_valid = 1'b0;
    repeat (5) tick();
`ifdef MIPS_CPU_STORE_COALESCE_EN
    n_cmp++; if (wr_n - base !== 1) begin n_bad++; $display("FAIL merge_write_count: got %0d want 1", wr_n - base); end
    n_cmp++; if (wr_be[base] !== 4'b1100) begin n_bad++; $display("FAIL merge_be: got %b want 1100", wr_be[base]); end
    n_cmp++; if (wr_data[base] !== 32'hEFCD0000) begin n_bad++; $display("FAIL merge_data: got %h want efcd0000", wr_data[base]); end
`else
    n_cmp++; if (wr_n - base !== 2) begin n_bad++; $display("FAIL sbsh_write_count: got %0d want 2", wr_n - base); end
    n_cmp++; if (wr_addr[base] !== 32'h200) begin n_bad++; $display("FAIL sb_addr: got %h want 00000200", wr_addr[base]); end
    n_cmp++; if (wr_be[base] !== 4'b1000) begin n_bad++; $display("FAIL sb_be: got %b want 1000", wr_be[base]); end
    n_cmp++; if (wr_data[base] !== 32'hAB000000) begin n_bad++; $display("FAIL sb_data: got %h want ab000000", wr_data[base]); end
    n_cmp++; if (wr_be[base+1] !== 4'b1100) begin n_bad++; $display("FAIL sh_be: got %b want 1100", wr_be[base+1]); end
    n_cmp++; if (wr_data[base+1] !== 32'hEFCD0000) begin n_bad++; $display("FAIL sh_data: got %h want efcd0000", wr_data[base+1]); end
`endif
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL sbsh_count_after: got %0d want 0", count); end
  endtask

  task automatic test_fill();
    int base;
    logic [31:0] exp_d;
    base = wr_n;
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_op = SW; st_addr = 32'h500 + 32'(4*i); st_data = 32'hA0A0A0A0 + 32'(i);
      tick();
    end
    st_addr = 32'h510; st_data = 32'hA0A0A0A4;
    #1;
    n_cmp++; if (st_ready !== 1'b0) begin n_bad++; $display("FAIL full_st_ready: got %b want 0", st_ready); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", count); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL hold_count[%0d]: got %0d want 4", i, count); end
      n_cmp++; if (st_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready[%0d]: got %b want 0", i, st_ready); end
      n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 32'h500) begin n_bad++; $display("FAIL hold_bus[%0d]: got write %b addr %h want 1 00000500", i, mem_write, mem_addr); end
    end
    mem_waitrequest = 1'b0;
    tick();
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL drain_first_count: got %0d want 3", count); end
    tick();
    st_valid = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL push_pop_count: got %0d want 3", count); end
    repeat (4) tick();
    n_cmp++; if (count !== 3'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL fill_drained: got count %0d empty %b want 0 1", count, empty); end
    n_cmp++; if (wr_n - base !== 5) begin n_bad++; $display("FAIL fill_write_count: got %0d want 5", wr_n - base); end
    for (int i = 0; i < 5; i++) begin
      exp_d = 32'hA0A0A0A0 + (32'(i) << 24);
      n_cmp++; if (wr_addr[base+i] !== 32'h500 + 32'(4*i)) begin n_bad++; $display("FAIL fill_addr[%0d]: got %h want %h", i, wr_addr[base+i], 32'h500 + 32'(4*i)); end
      n_cmp++; if (wr_data[base+i] !== exp_d) begin n_bad++; $display("FAIL fill_data[%0d]: got %h want %h", i, wr_data[base+i], exp_d); end
      if (i > 0) begin
        n_cmp++; if (wr_cyc[base+i] - wr_cyc[base+i-1] !== 1) begin n_bad++; $display("FAIL fill_spacing[%0d]: got %0d want 1", i, wr_cyc[base+i] - wr_cyc[base+i-1]); end
      end
    end
  endtask

  task automatic test_err();
    int base;
    base = wr_n;
    mem_waitrequest = 1'b0;
    st_valid = 1'b1; st_op = SH; st_addr = 32'h301; st_data = 32'h1234;
    #1;
    n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL err_ready: got %b want 1", st_ready); end
    tick();
    n_cmp++; if (st_err !== 1'b1) begin n_bad++; $display("FAIL err_sh: got %b want 1", st_err); end
    st_op = SW; st_addr = 32'h302;
    tick();
    n_cmp++; if (st_err !== 1'b1) begin n_bad++; $display("FAIL err_sw: got %b want 1", st_err); end
    st_op = 6'b100011; st_addr = 32'h300;
    tick();
    n_cmp++; if (st_err !== 1'b1) begin n_bad++; $display("FAIL err_op: got %b want 1", st_err); end
    st_valid = 1'b0;
    tick();
    n_cmp++; if (st_err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", st_err); end
    repeat (2) tick();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL err_count: got %0d want 0", count); end
    n_cmp++; if (wr_n - base !== 0) begin n_bad++; $display("FAIL err_writes: got %0d want 0", wr_n - base); end
  endtask

  task automatic test_hazard();
    mem_waitrequest = 1'b1;
    st_valid = 1'b1; st_op = SW; st_addr = 32'h400; st_data = 32'hDEADBEEF;
    tick();
    st_valid = 1'b0;
    ld_addr = 32'h402;
    #1;
    n_cmp++; if (ld_hazard !== 1'b1) begin n_bad++; $display("FAIL hz_match: got %b want 1", ld_hazard); end
    ld_addr = 32'h404;
    #1;
    n_cmp++; if (ld_hazard !== 1'b0) begin n_bad++; $display("FAIL hz_next_word: got %b want 0", ld_hazard); end
    ld_addr = 32'h400;
    tick();
    n_cmp++; if (mem_write !== 1'b1 || ld_hazard !== 1'b1) begin n_bad++; $display("FAIL hz_inflight: got write %b hazard %b want 1 1", mem_write, ld_hazard); end
    mem_waitrequest = 1'b0;
    #1;
    n_cmp++; if (ld_hazard !== 1'b1) begin n_bad++; $display("FAIL hz_accept_cycle: got %b want 1", ld_hazard); end
    tick();
    n_cmp++; if (ld_hazard !== 1'b0) begin n_bad++; $display("FAIL hz_after_pop: got %b want 0", ld_hazard); end
    ld_addr = 32'hFFFF_FFF0;
    tick();
  endtask

  task automatic test_reset_mid();
    int base;
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_op = SW; st_addr = 32'h600 + 32'(4*i); st_data = 32'h01020304;
      tick();
    end
    st_valid = 1'b0;
    n_cmp++; if (count !== 3'd3 || mem_write !== 1'b1) begin n_bad++; $display("FAIL pre_rst: got count %0d write %b want 3 1", count, mem_write); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL midrst_write: got %b want 0", mem_write); end
    n_cmp++; if (count !== 3'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL midrst_count: got count %0d empty %b want 0 1", count, empty); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    base = wr_n;
    repeat (5) tick();
    n_cmp++; if (wr_n - base !== 0) begin n_bad++; $display("FAIL midrst_no_retry: got %0d writes want 0", wr_n - base); end
    n_cmp++; if (count !== 3'd0 || mem_write !== 1'b0) begin n_bad++; $display("FAIL midrst_idle: got count %0d write %b want 0 0", count, mem_write); end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_sh();
    test_fill();
    test_err();
    test_hazard();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
